// File: rtl/alu_mdu.sv
// Multi-cycle RV32I/RV32M execute unit with valid/ready handshakes on both sides.
// ALU ops and divide corner cases finish in one edge; multiply/divide iterate XLEN times.
module alu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CntLast = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    // Accept-side decode and single-cycle results
    logic            is_mul, is_div, sign_a, sign_b, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, alu_res, fast_res;
    logic [SHW-1:0]  shamt;

    assign is_mul = (i_op[4:2] == 3'b100);
    assign is_div = (i_op[4:2] == 3'b101);
    assign sign_a = is_div ? ~i_op[0] : (is_mul && (i_op[1:0] == 2'b01 || i_op[1:0] == 2'b10));
    assign sign_b = is_div ? ~i_op[0] : (is_mul && (i_op[1:0] == 2'b01));
    assign a_neg  = sign_a & i_a[XLEN-1];
    assign b_neg  = sign_b & i_b[XLEN-1];
    assign mag_a  = a_neg ? -i_a : i_a;
    assign mag_b  = b_neg ? -i_b : i_b;
    assign shamt  = i_b[SHW-1:0];

    assign div_zero = (i_b == '0);
    assign div_ovf  = ~i_op[0] & (i_a == MinInt) & (&i_b);
    assign fast_res = i_op[1] ? (div_zero ? i_a : '0) : (div_zero ? '1 : MinInt);

    always_comb begin
        alu_res = '0;
        case (i_op)
            5'd0: alu_res = i_a + i_b;
            5'd1: alu_res = i_a - i_b;
            5'd2: alu_res = i_a & i_b;
            5'd3: alu_res = i_a | i_b;
            5'd4: alu_res = i_a ^ i_b;
            5'd5: alu_res = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            5'd6: alu_res = i_a << shamt;
            5'd7: alu_res = i_a >> shamt;
            5'd8: alu_res = $signed(i_a) >>> shamt;
            5'd9: alu_res = {{(XLEN-1){1'b0}}, i_a < i_b};
            default: alu_res = '0;
        endcase
    end

    // One shift-add multiply step on {hi, lo}; lo starts as the multiplier
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    assign prod     = {mul_hi_n, mul_lo_n};
    assign prod_s   = neg_q ? -prod : prod;
    assign mul_res  = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    // One restoring divide step: hi is the partial remainder, lo shifts dividend out/quotient in
    logic [XLEN:0]   rem_sh, diff;
    logic            q_bit;
    logic [XLEN-1:0] div_hi_n, div_lo_n, quo_s, rem_s, div_res;

    assign rem_sh   = {hi_q, lo_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, opb_q};
    assign q_bit    = ~diff[XLEN];
    assign div_hi_n = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign div_lo_n = {lo_q[XLEN-2:0], q_bit};
    assign quo_s    = neg_q ? -div_lo_n : div_lo_n;
    assign rem_s    = rneg_q ? -div_hi_n : div_hi_n;
    assign div_res  = op_q[1] ? rem_s : quo_s;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    op_d   = i_op;
                    cnt_d  = '0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    hi_d   = '0;
                    if (is_mul) begin
                        opb_d   = mag_a;
                        lo_d    = mag_b;
                        state_d = StMul;
                    end else if (is_div && (div_zero || div_ovf)) begin
                        result_d = fast_res;
                        state_d  = StDone;
                    end else if (is_div) begin
                        opb_d   = mag_b;
                        lo_d    = mag_a;
                        state_d = StDiv;
                    end else begin
                        result_d = alu_res;
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CntLast) begin
                    cnt_d    = '0;
                    result_d = mul_res;
                    state_d  = StDone;
                end
            end
            StDiv: begin
                hi_d  = div_hi_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CntLast) begin
                    cnt_d    = '0;
                    result_d = div_res;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (i_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything but leaves the last result visible
        if (i_flush) begin
            state_d  = StIdle;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = '0;
            result_d = result_q;
        end
    end

    assign zero_d = (result_d == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign o_ready  = (state_q == StIdle);
    assign o_valid  = (state_q == StDone);
    assign o_result = result_q;
    assign o_zero   = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (XLEN=32): ALU, multiply, divide, corner cases, backpressure,
// flush and asynchronous reset.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_flush;
    logic [4:0]  i_op;
    logic [31:0] i_a, i_b;
    logic        o_ready, o_valid, o_zero;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    alu_mdu #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_zero   (o_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one op, measure edges to o_valid, check result/zero/o_ready, then optionally drain.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit drain);
        int   n;
        logic rdy_ok;
        @(negedge clk);
        check({tag, " ready_in"}, {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_a     = 32'hDEAD_BEEF;
        i_b     = 32'h1234_5678;
        i_op    = 5'd1;
        n       = 1;
        rdy_ok  = 1'b1;
        while (o_valid !== 1'b1 && n < 80) begin
            if (o_ready !== 1'b0) rdy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        if (o_ready !== 1'b0) rdy_ok = 1'b0;
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, o_result, exp);
        check({tag, " zero"}, {31'd0, o_zero}, {31'd0, exp == 32'd0});
        check({tag, " busy"}, {31'd0, rdy_ok}, 32'd1);
        if (drain) begin
            @(negedge clk);
            i_ready = 1'b1;
            @(posedge clk);
            #1;
            i_ready = 1'b0;
            check({tag, " drained"}, {31'd0, o_valid}, 32'd0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        i_op    = '0;
        i_a     = '0;
        i_b     = '0;
        #1;
        check("rst valid", {31'd0, o_valid}, 32'd0);
        check("rst ready", {31'd0, o_ready}, 32'd1);
        check("rst result", o_result, 32'd0);
        check("rst zero", {31'd0, o_zero}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ALU ops
        run_op("ADD",  5'd0, 32'd2, 32'd3, 32'd5, 1, 1);
        run_op("SUB",  5'd1, 32'd5, 32'd5, 32'd0, 1, 1);
        run_op("AND",  5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 1);
        run_op("OR",   5'd3, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1, 1);
        run_op("XOR",  5'd4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1, 1);
        run_op("SLT",  5'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 1);
        run_op("SLL",  5'd6, 32'd1, 32'h0000_003F, 32'h8000_0000, 1, 1);
        run_op("SRL",  5'd7, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, 1);
        run_op("SRA",  5'd8, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1);
        run_op("SLTU", 5'd9, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 1);
        run_op("ILL",  5'd31, 32'd7, 32'd9, 32'd0, 1, 1);

        // Multiply
        run_op("MULH",   5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33, 1);
        run_op("MULHU",  5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1);
        run_op("MUL",    5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1);
        run_op("MULHSU", 5'd18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1);

        // Divide
        run_op("DIV",  5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1);
        run_op("REM",  5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1);
        run_op("DIVU", 5'd21, 32'd100, 32'd7, 32'd14, 33, 1);
        run_op("REMU", 5'd23, 32'd100, 32'd7, 32'd2, 33, 1);

        // Fast cases
        run_op("DIVovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        run_op("REMovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);
        run_op("DIVU0",   5'd21, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1);
        run_op("REMU0",   5'd23, 32'd9, 32'd0, 32'd9, 1, 1);
        run_op("DIV0",    5'd20, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1);

        // Backpressure: hold DONE, present a new request that must wait
        run_op("BP", 5'd21, 32'd100, 32'd7, 32'd14, 33, 0);
        @(negedge clk);
        i_valid = 1'b1;
        i_op    = 5'd0;
        i_a     = 32'd2;
        i_b     = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("BP hold valid", {31'd0, o_valid}, 32'd1);
            check("BP hold result", o_result, 32'd14);
            check("BP hold ready", {31'd0, o_ready}, 32'd0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check("BP release valid", {31'd0, o_valid}, 32'd0);
        check("BP release ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("BP next valid", {31'd0, o_valid}, 32'd1);
        check("BP next result", o_result, 32'd5);
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;

        // Flush at iteration 10 of a divide
        @(negedge clk);
        i_valid = 1'b1;
        i_op    = 5'd21;
        i_a     = 32'd1000;
        i_b     = 32'd3;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check("FL ready", {31'd0, o_ready}, 32'd1);
        check("FL valid", {31'd0, o_valid}, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (o_valid === 1'b1) seen = 1'b1;
            end
            check("FL no valid", {31'd0, seen}, 32'd0);
        end
        check("FL result kept", o_result, 32'd5);

        // Asynchronous reset mid-multiply
        @(negedge clk);
        i_valid = 1'b1;
        i_op    = 5'd16;
        i_a     = 32'd6;
        i_b     = 32'd7;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("AR pre ready", {31'd0, o_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("AR valid", {31'd0, o_valid}, 32'd0);
        check("AR result", o_result, 32'd0);
        check("AR zero", {31'd0, o_zero}, 32'd1);
        check("AR ready", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op("ADDpost", 5'd0, 32'd2, 32'd3, 32'd5, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
